// File: rtl/decode_inst_queue_pkg.sv
// Shared MIPS-I opcode/funct/rt constants and exception-code bit positions
// used by the fetch/decode instruction queue and its pre-decoder.
package decode_inst_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int EXC_W   = 8;

  // exc_code bit positions: {4'b0, ri, syscall, break, eret}
  localparam int EXC_ERET_BIT    = 0;
  localparam int EXC_BREAK_BIT   = 1;
  localparam int EXC_SYSCALL_BIT = 2;
  localparam int EXC_RI_BIT      = 3;

  // primary opcodes
  localparam logic [5:0] R_TYPE      = 6'h00;
  localparam logic [5:0] REGIMM_INST = 6'h01;
  localparam logic [5:0] J_INST      = 6'h02;
  localparam logic [5:0] JAL_INST    = 6'h03;
  localparam logic [5:0] BEQ         = 6'h04;
  localparam logic [5:0] BNE         = 6'h05;
  localparam logic [5:0] BLEZ        = 6'h06;
  localparam logic [5:0] BGTZ        = 6'h07;
  localparam logic [5:0] ADDI        = 6'h08;
  localparam logic [5:0] ADDIU       = 6'h09;
  localparam logic [5:0] SLTI        = 6'h0a;
  localparam logic [5:0] SLTIU       = 6'h0b;
  localparam logic [5:0] ANDI        = 6'h0c;
  localparam logic [5:0] ORI         = 6'h0d;
  localparam logic [5:0] XORI        = 6'h0e;
  localparam logic [5:0] LUI         = 6'h0f;
  localparam logic [5:0] COP0_INST   = 6'h10;
  localparam logic [5:0] LB          = 6'h20;
  localparam logic [5:0] LH          = 6'h21;
  localparam logic [5:0] LW          = 6'h23;
  localparam logic [5:0] LBU         = 6'h24;
  localparam logic [5:0] LHU         = 6'h25;
  localparam logic [5:0] SB          = 6'h28;
  localparam logic [5:0] SH          = 6'h29;
  localparam logic [5:0] SW          = 6'h2b;

  // R_TYPE funct codes
  localparam logic [5:0] SLL     = 6'h00;
  localparam logic [5:0] SRL     = 6'h02;
  localparam logic [5:0] SRA     = 6'h03;
  localparam logic [5:0] SLLV    = 6'h04;
  localparam logic [5:0] SRLV    = 6'h06;
  localparam logic [5:0] SRAV    = 6'h07;
  localparam logic [5:0] JR      = 6'h08;
  localparam logic [5:0] JALR    = 6'h09;
  localparam logic [5:0] SYSCALL = 6'h0c;
  localparam logic [5:0] BREAK   = 6'h0d;
  localparam logic [5:0] MFHI    = 6'h10;
  localparam logic [5:0] MTHI    = 6'h11;
  localparam logic [5:0] MFLO    = 6'h12;
  localparam logic [5:0] MTLO    = 6'h13;
  localparam logic [5:0] MULT    = 6'h18;
  localparam logic [5:0] MULTU   = 6'h19;
  localparam logic [5:0] DIV     = 6'h1a;
  localparam logic [5:0] DIVU    = 6'h1b;
  localparam logic [5:0] ADD     = 6'h20;
  localparam logic [5:0] ADDU    = 6'h21;
  localparam logic [5:0] SUB     = 6'h22;
  localparam logic [5:0] SUBU    = 6'h23;
  localparam logic [5:0] AND_OP  = 6'h24;
  localparam logic [5:0] OR_OP   = 6'h25;
  localparam logic [5:0] XOR_OP  = 6'h26;
  localparam logic [5:0] NOR_OP  = 6'h27;
  localparam logic [5:0] SLT     = 6'h2a;
  localparam logic [5:0] SLTU    = 6'h2b;

  // REGIMM rt codes
  localparam logic [4:0] BLTZ   = 5'h00;
  localparam logic [4:0] BGEZ   = 5'h01;
  localparam logic [4:0] BLTZAL = 5'h10;
  localparam logic [4:0] BGEZAL = 5'h11;

  // COP0 rs codes
  localparam logic [4:0] MFC0 = 5'h00;
  localparam logic [4:0] MTC0 = 5'h04;

  localparam logic [INSTR_W-1:0] ERET = 32'h42000018;

endpackage

// File: rtl/decode_inst_queue_predecode.sv
// Combinational pre-decoder: classifies one instruction word as branch/jump
// and flags the exceptions decode will need (eret, break, syscall, reserved).
module inst_predecode
  import decode_inst_queue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               is_branch,
  output logic [EXC_W-1:0]   exc_code
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [10:0] low_bits;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign funct    = instr[5:0];
  assign low_bits = instr[10:0];

  logic ri;
  logic is_syscall;
  logic is_break;
  logic is_eret;

  // Classify the word; anything not matched below stays reserved.
  always_comb begin
    is_branch  = 1'b0;
    ri         = 1'b1;
    is_syscall = 1'b0;
    is_break   = 1'b0;
    is_eret    = 1'b0;
    if (instr == ERET) begin
      is_eret = 1'b1;
      ri      = 1'b0;
    end else begin
      case (opcode)
        R_TYPE: begin
          case (funct)
            JR, JALR: begin
              is_branch = 1'b1;
              ri        = 1'b0;
            end
            SYSCALL: begin
              is_syscall = 1'b1;
              ri         = 1'b0;
            end
            BREAK: begin
              is_break = 1'b1;
              ri       = 1'b0;
            end
            SLL, SRL, SRA, SLLV, SRLV, SRAV,
            MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU,
            ADD, ADDU, SUB, SUBU, AND_OP, OR_OP, XOR_OP, NOR_OP,
            SLT, SLTU: ri = 1'b0;
            default:   ri = 1'b1;
          endcase
        end
        REGIMM_INST: begin
          if (rt == BLTZ || rt == BGEZ || rt == BLTZAL || rt == BGEZAL) begin
            is_branch = 1'b1;
            ri        = 1'b0;
          end
        end
        BEQ, BNE, J_INST, JAL_INST: begin
          is_branch = 1'b1;
          ri        = 1'b0;
        end
        BLEZ, BGTZ: begin
          if (rt == '0) begin
            is_branch = 1'b1;
            ri        = 1'b0;
          end
        end
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI: ri = 1'b0;
        LUI: ri = (rs != '0);
        COP0_INST: ri = !(((rs == MFC0) || (rs == MTC0)) && (low_bits == '0));
        default: ri = 1'b1;
      endcase
    end
  end

  // Pack the flags into the exception code byte.
  always_comb begin
    exc_code                  = '0;
    exc_code[EXC_ERET_BIT]    = is_eret;
    exc_code[EXC_BREAK_BIT]   = is_break;
    exc_code[EXC_SYSCALL_BIT] = is_syscall;
    exc_code[EXC_RI_BIT]      = ri;
  end

endmodule

// File: rtl/decode_inst_queue.sv
// Instruction queue between fetch and decode. Words are pre-decoded as they
// are pushed and the flags are stored with each entry, so decode sees them
// registered on the head. A decode stall never back-pressures fetch until
// the queue is actually full.
module decode_inst_queue
  import decode_inst_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]        in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_instr,
  output logic                     out_is_in_slot,
  output logic                     out_is_branch,
  output logic [EXC_W-1:0]         out_exc_code,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PTR_W   = AW + 1;
  localparam int ENTRY_W = 2 * DATA_W + 1 + 1 + EXC_W;

  // Entry layout, MSB first: {pc, instr, in_slot, is_branch, exc_code}
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] count_q;
  logic             prev_branch_q;

  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  logic             pd_branch;
  logic [EXC_W-1:0] pd_exc;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);

  // Flush wins over both handshakes; the word offered alongside it is lost.
  assign push = in_valid && !full && !flush;
  assign pop  = out_ready && !empty && !flush;

  inst_predecode u_predecode (
    .instr     (in_instr[INSTR_W-1:0]),
    .is_branch (pd_branch),
    .exc_code  (pd_exc)
  );

  // Entry storage: written at the tail on push, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[tail_idx] <= {in_pc, in_instr, prev_branch_q, pd_branch, pd_exc};
    end
  end

  // Pointers, occupancy and delay-slot tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      prev_branch_q <= 1'b0;
    end else if (flush) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      prev_branch_q <= 1'b0;
    end else begin
      if (push) begin
        tail_q        <= tail_q + PTR_W'(1);
        prev_branch_q <= pd_branch;
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + PTR_W'(1);
        2'b01:   count_q <= count_q - PTR_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head presentation; an empty queue shows the reset pc and clear flags.
  always_comb begin
    out_pc         = RESET_PC;
    out_instr      = '0;
    out_is_in_slot = 1'b0;
    out_is_branch  = 1'b0;
    out_exc_code   = '0;
    if (!empty) begin
      {out_pc, out_instr, out_is_in_slot, out_is_branch, out_exc_code} = mem_q[head_idx];
    end
  end

  assign out_valid = !empty;
  assign in_ready  = !full;
  assign count     = count_q;

endmodule

// File: tb/tb_decode_inst_queue.sv
module tb_decode_inst_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_is_in_slot;
  logic        out_is_branch;
  logic [7:0]  out_exc_code;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  decode_inst_queue #(.DEPTH(DEPTH), .DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_is_in_slot (out_is_in_slot),
    .out_is_branch  (out_is_branch),
    .out_exc_code   (out_exc_code),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        slot;
    logic        br;
    logic [7:0]  exc;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic        br;
    logic [7:0]  exc;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1; in_pc = pc; in_instr = ins; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, ".valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".count"}, 64'(count), 64'd0);
    chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, ".pc"}, 64'(out_pc), 64'(RST_PC));
    chk({nm, ".instr"}, 64'(out_instr), 64'd0);
    chk({nm, ".flags"}, 64'({out_is_in_slot, out_is_branch, out_exc_code}), 64'd0);
  endtask

  // Reference pre-decode, written from the instruction-set rules directly.
  function automatic logic [8:0] ref_pd(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic br, er, sc, bk, legal;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; fn = w[5:0];
    er = (w == 32'h42000018);
    br = (op inside {6'h02, 6'h03, 6'h04, 6'h05})
      || ((op inside {6'h06, 6'h07}) && rt == 5'd0)
      || (op == 6'h01 && (rt inside {5'h00, 5'h01, 5'h10, 5'h11}))
      || (op == 6'h00 && (fn inside {6'h08, 6'h09}));
    sc = (op == 6'h00 && fn == 6'h0c);
    bk = (op == 6'h00 && fn == 6'h0d);
    legal = er || br
      || (op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0c, 6'h0d,
                                     6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b,
                                     [6'h20:6'h27], 6'h2a, 6'h2b}))
      || (op inside {[6'h08:6'h0e], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b})
      || (op == 6'h0f && rs == 5'd0)
      || (op == 6'h10 && (rs inside {5'h00, 5'h04}) && w[10:0] == 11'd0);
    return {br, 4'b0, !legal, sc, bk, er};
  endfunction

  ent_t        mq[$];
  logic        prev_m;
  vec_t        vecs[$];
  logic [31:0] pool[$];

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;

    vecs = '{
      '{32'h3c080001, 1'b0, 8'h00}, '{32'h11090003, 1'b1, 8'h00},
      '{32'h0000000c, 1'b0, 8'h04}, '{32'h0000000d, 1'b0, 8'h02},
      '{32'h42000018, 1'b0, 8'h01}, '{32'hfc000000, 1'b0, 8'h08},
      '{32'h00000000, 1'b0, 8'h00}, '{32'h08000010, 1'b1, 8'h00},
      '{32'h0c000010, 1'b1, 8'h00}, '{32'h03e00008, 1'b1, 8'h00},
      '{32'h0040f809, 1'b1, 8'h00}, '{32'h04110002, 1'b1, 8'h00},
      '{32'h04020002, 1'b0, 8'h08}, '{32'h1c200003, 1'b1, 8'h00},
      '{32'h1c210003, 1'b0, 8'h08}, '{32'h3c210001, 1'b0, 8'h08},
      '{32'h40086000, 1'b0, 8'h00}, '{32'h40086001, 1'b0, 8'h08},
      '{32'h8c880004, 1'b0, 8'h00}, '{32'h00000001, 1'b0, 8'h08},
      '{32'h00850018, 1'b0, 8'h00}, '{32'h0000000f, 1'b0, 8'h08}
    };

    #12;
    resetn = 1'b1;

    // 1: reset state, then one push with decode stalled
    chk_empty("reset");
    push_one(32'hbfc00000, 32'h3c080001);
    chk("t1.valid", 64'(out_valid), 64'd1);
    chk("t1.pc", 64'(out_pc), 64'hbfc00000);
    chk("t1.branch", 64'(out_is_branch), 64'd0);
    chk("t1.exc", 64'(out_exc_code), 64'h00);
    chk("t1.count", 64'(count), 64'd1);

    // 2: fill, refuse 5th, pop with fetch still offering
    do_flush();
    for (int i = 0; i < 4; i++) push_one(32'h1000 + 32'(i * 4), 32'h0);
    chk("t2.count_full", 64'(count), 64'd4);
    chk("t2.in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_pc = 32'h2000; out_ready = 1'b1;
    tick();
    chk("t2.pop_while_full", 64'(count), 64'd3);
    out_ready = 1'b0;
    tick();
    chk("t2.count_refill", 64'(count), 64'd4);
    chk("t2.head_pc", 64'(out_pc), 64'h1004);
    in_valid = 1'b0;

    // table: pre-decode of individual words
    foreach (vecs[i]) begin
      do_flush();
      push_one(32'h4000 + 32'(i * 4), vecs[i].instr);
      chk($sformatf("vec%0d.branch", i), 64'(out_is_branch), 64'(vecs[i].br));
      chk($sformatf("vec%0d.exc", i), 64'(out_exc_code), 64'(vecs[i].exc));
      chk($sformatf("vec%0d.slot", i), 64'(out_is_in_slot), 64'd0);
      chk($sformatf("vec%0d.model", i), 64'({out_is_branch, out_exc_code}), 64'(ref_pd(vecs[i].instr)));
    end

    // 3: beq then nop -> nop is the delay slot
    do_flush();
    push_one(32'h500, 32'h11090003);
    push_one(32'h504, 32'h00000000);
    chk("t3.beq_br", 64'(out_is_branch), 64'd1);
    chk("t3.beq_slot", 64'(out_is_in_slot), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3.nop_pc", 64'(out_pc), 64'h504);
    chk("t3.nop_slot", 64'(out_is_in_slot), 64'd1);
    chk("t3.nop_br", 64'(out_is_branch), 64'd0);

    // 5: flush beats push and pop; slot history cleared
    do_flush();
    push_one(32'h600, 32'h0);
    push_one(32'h604, 32'h0);
    push_one(32'h608, 32'h08000010);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h60c; in_instr = 32'h0; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("t5.count", 64'(count), 64'd0);
    chk("t5.valid", 64'(out_valid), 64'd0);
    chk("t5.pc", 64'(out_pc), 64'(RST_PC));
    push_one(32'h700, 32'h0);
    chk("t5.slot_after_flush", 64'(out_is_in_slot), 64'd0);
    chk("t5.pc_after_flush", 64'(out_pc), 64'h700);

    // 6: streaming across pointer wrap, then async reset mid-stream
    do_flush();
    begin
      int k, npop;
      k = 0; npop = 0;
      for (int cyc = 0; cyc < 60 && npop < 10; cyc++) begin
        in_valid  = (k < 10);
        in_pc     = 32'h80000000 + 32'(k * 4);
        in_instr  = 32'h0;
        out_ready = cyc[0];
        if (out_valid && out_ready) begin
          chk($sformatf("t6.pop%0d", npop), 64'(out_pc), 64'(32'h80000000 + 32'(npop * 4)));
          npop++;
        end
        if (in_valid && in_ready) k++;
        tick();
      end
      chk("t6.drained", 64'(npop), 64'd10);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    push_one(32'h900, 32'h11090003);
    push_one(32'h904, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    chk_empty("t6.async_reset");
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk_empty("t6.after_reset");

    // randomized traffic against the queue model
    pool = '{32'h11090003, 32'h00000000, 32'h0000000c, 32'h0000000d, 32'h42000018,
             32'h08000010, 32'h03e00008, 32'h3c080001, 32'h04110002, 32'h8c880004};
    mq.delete();
    prev_m = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic fl, iv, ordy;
      logic [31:0] w;
      int sel;
      fl   = ($urandom_range(0, 29) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) == 0) ? 1'b1 : cyc[1];
      sel  = $urandom_range(0, 3);
      if (sel < 2)       w = pool[$urandom_range(0, pool.size() - 1)];
      else if (sel == 2) w = $urandom;
      else               w = {$urandom_range(0, 15) == 0 ? 6'h10 : 6'($urandom_range(0, 15)), 26'($urandom)};
      flush = fl; in_valid = iv; in_pc = $urandom; in_instr = w; out_ready = ordy;
      if (fl) begin
        mq.delete();
        prev_m = 1'b0;
      end else begin
        logic [8:0] pd;
        logic was_full;
        was_full = (mq.size() == DEPTH);
        if (ordy && mq.size() != 0) void'(mq.pop_front());
        if (iv && !was_full) begin
          pd = ref_pd(w);
          mq.push_back('{in_pc, w, prev_m, pd[8], pd[7:0]});
          prev_m = pd[8];
        end
      end
      tick();
      chk("rnd.count", 64'(count), 64'(mq.size()));
      chk("rnd.valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("rnd.in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
      if (mq.size() != 0) begin
        chk("rnd.head", {out_pc, out_instr}, {mq[0].pc, mq[0].instr});
        chk("rnd.flags", 64'({out_is_in_slot, out_is_branch, out_exc_code}),
            64'({mq[0].slot, mq[0].br, mq[0].exc}));
      end else begin
        chk("rnd.empty_out", {out_pc, out_instr}, {RST_PC, 32'h0});
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
